// File: rtl/cprv_if_stage.sv
// cprv64g instruction-fetch stage: PC, imem request, 2-entry output FIFO.
// Optional: define CPRV_IF_MISALIGN_EN to trap misaligned redirect targets.
module cprv_if_stage #(
    parameter int              XLEN       = 64,
    parameter int              ADDR_WIDTH = 7,
    parameter int              DATA_WIDTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  imem_w_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
`ifdef CPRV_IF_MISALIGN_EN
    output logic                  id_exc,
`endif
    output logic [XLEN-1:0]       id_pc,
    output logic [31:0]           id_instr
);

    localparam logic [31:0] NOP = 32'h00000013;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] fpc_q [2];
    logic [XLEN-1:0] fpc_d [2];
    logic [31:0]     fins_q [2];
    logic [31:0]     fins_d [2];
    logic [1:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] fetch_pc;
    logic            pop;
    logic            push;
    logic            issue;
    logic            room;
    logic [2:0]      occ;
    logic            unused_ok;

`ifdef CPRV_IF_MISALIGN_EN
    logic [1:0] fexc_q, fexc_d;
    logic       halt_q, halt_d;
    logic       misal;

    assign misal     = redirect & (|redirect_pc[1:0]);
    assign fetch_pc  = redirect ? redirect_pc : pc_q;
    assign unused_ok = ^imem_rdata[DATA_WIDTH-1:32];
    assign id_exc    = id_valid & fexc_q[0];
`else
    assign fetch_pc  = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : pc_q;
    assign unused_ok = ^{imem_rdata[DATA_WIDTH-1:32], redirect_pc[1:0]};
`endif

    assign imem_w_en  = 1'b0;
    assign imem_wdata = '0;
    assign imem_addr  = fetch_pc[ADDR_WIDTH-1:0];

    assign id_valid = (cnt_q != 2'd0);
    assign id_pc    = fpc_q[0];
    assign id_instr = fins_q[0];

    assign pop  = id_valid & id_ready;
    assign push = inflight_q & ~redirect;
    assign occ  = {1'b0, cnt_q} + {2'b00, inflight_q};
    // Only fetch if the result is guaranteed a FIFO slot when it returns.
    assign room = (occ < (3'd2 + {2'b00, pop}));

`ifdef CPRV_IF_MISALIGN_EN
    assign issue = redirect ? ~misal : (~halt_q & room);
`else
    assign issue = redirect | room;
`endif

    // Next fetch PC and outstanding-request tracking.
    always_comb begin
        inflight_d = issue;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        if (issue) begin
            pc_d     = fetch_pc + XLEN'(4);
            req_pc_d = fetch_pc;
        end
    end

    // FIFO update: flush on redirect, otherwise pop then append response.
    always_comb begin
        fpc_d  = fpc_q;
        fins_d = fins_q;
        cnt_d  = cnt_q;
`ifdef CPRV_IF_MISALIGN_EN
        fexc_d = fexc_q;
        halt_d = redirect ? misal : halt_q;
`endif
        if (redirect) begin
            cnt_d = 2'd0;
`ifdef CPRV_IF_MISALIGN_EN
            if (misal) begin
                fpc_d[0]  = redirect_pc;
                fins_d[0] = NOP;
                fexc_d[0] = 1'b1;
                cnt_d     = 2'd1;
            end
`endif
        end else begin
            if (pop) begin
                if (cnt_q[1]) begin
                    fpc_d[0]  = fpc_q[1];
                    fins_d[0] = fins_q[1];
`ifdef CPRV_IF_MISALIGN_EN
                    fexc_d[0] = fexc_q[1];
`endif
                end
                cnt_d = cnt_q - 2'd1;
            end
            if (push) begin
                fpc_d[cnt_d[0]]  = req_pc_q;
                fins_d[cnt_d[0]] = imem_rdata[31:0];
`ifdef CPRV_IF_MISALIGN_EN
                fexc_d[cnt_d[0]] = 1'b0;
`endif
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            fpc_q[0]   <= '0;
            fpc_q[1]   <= '0;
            fins_q[0]  <= '0;
            fins_q[1]  <= '0;
            cnt_q      <= 2'd0;
`ifdef CPRV_IF_MISALIGN_EN
            fexc_q     <= 2'b00;
            halt_q     <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            fpc_q      <= fpc_d;
            fins_q     <= fins_d;
            cnt_q      <= cnt_d;
`ifdef CPRV_IF_MISALIGN_EN
            fexc_q     <= fexc_d;
            halt_q     <= halt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cprv_if_stage.sv
// Randomized bench for cprv_if_stage against a PC-stream reference model.
// A second instance with RESET_PC near 2^64 checks PC wrap-around.
module tb_cprv_if_stage;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_w_en;
    logic [6:0]  imem_addr;
    logic [63:0] imem_wdata;
    logic [63:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;

    logic        w_w_en;
    logic [6:0]  w_addr;
    logic [63:0] w_wdata;
    logic [63:0] w_rdata;
    logic        w_valid;
    logic [63:0] w_pc;
    logic [31:0] w_instr;
    logic        w_redirect = 1'b0;
    logic [63:0] w_rpc = '0;
    logic        w_ready = 1'b1;

`ifdef CPRV_IF_MISALIGN_EN
    logic id_exc;
    logic w_exc;
`endif

    logic [63:0] mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= mem[imem_addr[6:2]];
        w_rdata    <= mem[w_addr[6:2]];
    end

    cprv_if_stage dut (
        .clk(clk), .rst_n(rst_n),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_w_en(imem_w_en), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
`ifdef CPRV_IF_MISALIGN_EN
        .id_exc(id_exc),
`endif
        .id_pc(id_pc), .id_instr(id_instr)
    );

    cprv_if_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect(w_redirect), .redirect_pc(w_rpc),
        .imem_w_en(w_w_en), .imem_addr(w_addr),
        .imem_wdata(w_wdata), .imem_rdata(w_rdata),
        .id_valid(w_valid), .id_ready(w_ready),
`ifdef CPRV_IF_MISALIGN_EN
        .id_exc(w_exc),
`endif
        .id_pc(w_pc), .id_instr(w_instr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the delivered stream is just consecutive PCs from the
    // last restart point; output is valid from the second cycle after it.
    bit          inrst;
    bit          jr;
    int          age;
    int          w_age;
    logic [63:0] exp_pc;
    logic [63:0] w_exp;
    bit          stall_addr;

    function automatic logic [31:0] instr_at(input logic [63:0] pc);
        logic [63:0] w;
        w = mem[pc[6:2]];
        return w[31:0];
    endfunction

    task automatic step();
        logic [63:0] t;
        @(negedge clk);
        chk("valid", {63'd0, id_valid}, {63'd0, (!inrst && age >= 1)});
        chk("w_valid", {63'd0, w_valid}, {63'd0, (!inrst && w_age >= 1)});
        if (jr) begin
            chk("rst_pc", id_pc, 64'd0);
            chk("rst_instr", {32'd0, id_instr}, 64'd0);
        end
        if (id_valid) begin
            chk("pc", id_pc, exp_pc);
            chk("instr", {32'd0, id_instr}, {32'd0, instr_at(exp_pc)});
`ifdef CPRV_IF_MISALIGN_EN
            chk("exc", {63'd0, id_exc}, 64'd0);
`endif
            if (id_ready) exp_pc = exp_pc + 64'd4;
        end
        if (w_valid) begin
            chk("w_pc", w_pc, w_exp);
            chk("w_instr", {32'd0, w_instr}, {32'd0, instr_at(w_exp)});
            w_exp = w_exp + 64'd4;
        end
        if (stall_addr) begin
            t = exp_pc + 64'd8;
            chk("stall_addr", {57'd0, imem_addr}, {57'd0, t[6:0]});
        end
        if (redirect && rst_n)
            chk("redir_addr", {57'd0, imem_addr},
                {57'd0, redirect_pc[6:2], 2'b00});
        @(posedge clk);
        if (!rst_n) begin
            inrst = 1;
            jr    = 1;
        end else begin
            jr = 0;
            if (redirect || inrst) begin
                age    = 0;
                exp_pc = redirect ? {redirect_pc[63:2], 2'b00} : 64'd0;
            end else begin
                age++;
            end
            if (inrst) begin
                w_age = 0;
                w_exp = WRAP_PC;
            end else begin
                w_age++;
            end
            inrst = 0;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 18; i++) mem[i][31:0] = 32'h00108093;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        stall_addr  = 0;
        age         = 0;
        w_age       = 0;
        exp_pc      = '0;
        w_exp       = WRAP_PC;
        @(posedge clk);
        #1;
        inrst = 1;
        jr    = 1;

        // Reset release, steady stream, wrap instance alongside.
        rst_n = 1'b1;
        run(20);

        // Decode stall for 5 cycles.
        id_ready = 1'b0;
        step();
        stall_addr = 1;
        run(4);
        stall_addr = 0;
        id_ready   = 1'b1;
        run(6);

        // Redirect while the FIFO is full.
        id_ready = 1'b0;
        run(3);
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        run(10);

        // Back-to-back redirects.
        redirect    = 1'b1;
        redirect_pc = 64'h10;
        step();
        redirect_pc = 64'h64;
        step();
        redirect = 1'b0;
        run(6);

        // Reset with full FIFO and decode stalled.
        id_ready = 1'b0;
        run(3);
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        run(10);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = {$urandom, $urandom};
`ifdef CPRV_IF_MISALIGN_EN
            redirect_pc[1:0] = 2'b00;
`endif
            id_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n    = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b1;
        run(5);

`ifdef CPRV_IF_MISALIGN_EN
        // Misaligned redirect raises a single exception entry, then halts.
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h42;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mis_valid", {63'd0, id_valid}, 64'd1);
            chk("mis_exc", {63'd0, id_exc}, 64'd1);
            chk("mis_pc", id_pc, 64'h42);
            chk("mis_instr", {32'd0, id_instr}, 64'h13);
            if (k == 1) id_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_valid", {63'd0, id_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        redirect    = 1'b1;
        redirect_pc = 64'h80;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("res_valid0", {63'd0, id_valid}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("res_valid1", {63'd0, id_valid}, 64'd1);
        chk("res_pc", id_pc, 64'h80);
        chk("res_exc", {63'd0, id_exc}, 64'd0);
        chk("res_instr", {32'd0, id_instr}, {32'd0, instr_at(64'h80)});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
